vx_hw_itr_ctrl: RTL and testbench

Per-core hardware interrupt controller. It is the responder on the VX_sfu_csr_if bus driven by the core CSR unit for addresses in [`VX_HW_ITR_CTRL_BEGIN, `VX_HW_ITR_CTRL_END).
- Latches external interrupt edges and software raises into a pending register.
- Arbitrates pending sources by fixed priority.
- Delivers one interrupt at a time to the warp scheduler via a valid/ready request, then holds it in service until software writes EOI.

---
 rtl/vx_hw_itr_ctrl_pkg.sv | 27 ++
 rtl/vx_hw_itr_ctrl_prio.sv | 20 ++
 rtl/vx_hw_itr_ctrl.sv | 148 ++++++++++++++
 tb/tb_vx_hw_itr_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_hw_itr_ctrl_pkg.sv
// rtl/vx_hw_itr_ctrl_pkg.sv - shared types and CSR map for the hardware interrupt controller
package vx_hw_itr_ctrl_pkg;

  typedef enum logic [1:0] {
    ITR_IDLE   = 2'd0,
    ITR_REQ    = 2'd1,
    ITR_ACTIVE = 2'd2
  } itr_state_t;

  // BEGIN must stay 8-aligned: the register offset is taken straight from addr[2:0].
  localparam logic [11:0] HW_ITR_CTRL_BEGIN = 12'h7C0;
  localparam logic [11:0] HW_ITR_CTRL_END   = 12'h7C8;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_PENDING = 3'd2;
  localparam logic [2:0] OFF_CAUSE   = 3'd3;
  localparam logic [2:0] OFF_TARGET  = 3'd4;
  localparam logic [2:0] OFF_HANDLER = 3'd5;
  localparam logic [2:0] OFF_EOI     = 3'd6;
  localparam logic [2:0] OFF_RAISE   = 3'd7;

  function automatic logic in_window(input logic [11:0] addr);
    return (addr >= HW_ITR_CTRL_BEGIN) && (addr < HW_ITR_CTRL_END);
  endfunction

endpackage

// File: rtl/vx_hw_itr_ctrl_prio.sv
// rtl/vx_hw_itr_ctrl_prio.sv - lowest-index-wins priority encoder
module vx_hw_itr_ctrl_prio #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_data,
  output logic [W-1:0] o_index,
  output logic         o_valid
);

  always_comb begin
    o_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_data[i]) o_index = W'(i);
    end
  end

  assign o_valid = |i_data;

endmodule

// File: rtl/vx_hw_itr_ctrl.sv
// rtl/vx_hw_itr_ctrl.sv - per-core interrupt controller: pending latch, priority pick, delivery FSM
module vx_hw_itr_ctrl
  import vx_hw_itr_ctrl_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int WARP_CNT  = 4,
  parameter int NUM_SRCS  = 8,
  parameter int XLEN      = 32,
  parameter int SRC_BITS  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1,
  parameter int WID_BITS  = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_read_enable,
  input  logic [11:0]               i_read_addr,
  output logic [NUM_LANES*32-1:0]   o_read_data,
  input  logic                      i_write_enable,
  input  logic [11:0]               i_write_addr,
  input  logic [NUM_LANES*32-1:0]   i_write_data,
  input  logic [NUM_SRCS-1:0]       i_irq_in,
  output logic                      o_itr_valid,
  output logic [WID_BITS-1:0]       o_itr_wid,
  output logic [XLEN-1:0]           o_itr_pc,
  output logic [SRC_BITS-1:0]       o_itr_cause,
  input  logic                      i_itr_ready
);

  logic                r_gie;
  logic [NUM_SRCS-1:0] r_enable;
  logic [NUM_SRCS-1:0] r_pending;
  logic [NUM_SRCS-1:0] r_irq_prev;
  logic [WID_BITS-1:0] r_target;
  logic [31:0]         r_handler;
  itr_state_t          r_state;
  logic                r_valid;
  logic [WID_BITS-1:0] r_wid;
  logic [31:0]         r_pc;
  logic [SRC_BITS-1:0] r_cause;

  logic                w_unused;
  logic                w_wr_hit;
  logic [2:0]          w_woff;
  logic [31:0]         w_wdata;
  logic [NUM_SRCS-1:0] w_rise;
  logic [NUM_SRCS-1:0] w_set;
  logic [NUM_SRCS-1:0] w_w1c;
  logic [NUM_SRCS-1:0] w_deliver;
  logic [NUM_SRCS-1:0] w_pending_nxt;
  logic [SRC_BITS-1:0] w_idx;
  logic                w_any;
  logic                w_fire;
  logic [31:0]         w_rdata;

  assign w_unused = ^{i_read_enable, i_write_data};
  assign w_wr_hit = i_write_enable && in_window(i_write_addr);
  assign w_woff   = i_write_addr[2:0];
  assign w_wdata  = i_write_data[31:0];

  assign w_rise = i_irq_in & ~r_irq_prev;
  assign w_set  = w_rise | ((w_wr_hit && w_woff == OFF_RAISE) ? w_wdata[NUM_SRCS-1:0] : '0);
  assign w_w1c  = (w_wr_hit && w_woff == OFF_PENDING) ? w_wdata[NUM_SRCS-1:0] : '0;

  vx_hw_itr_ctrl_prio #(
    .N (NUM_SRCS),
    .W (SRC_BITS)
  ) u_prio (
    .i_data  (r_pending & r_enable),
    .o_index (w_idx),
    .o_valid (w_any)
  );

  assign w_fire    = (r_state == ITR_IDLE) && r_gie && w_any;
  assign w_deliver = w_fire ? (NUM_SRCS'(1) << w_idx) : '0;
  // A new set beats W1C; the delivery clear beats everything, dropping a coincident edge.
  assign w_pending_nxt = ((r_pending | w_set) & ~(w_w1c & ~w_set)) & ~w_deliver;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gie      <= 1'b0;
      r_enable   <= '0;
      r_pending  <= '0;
      r_irq_prev <= '0;
      r_target   <= '0;
      r_handler  <= '0;
      r_state    <= ITR_IDLE;
      r_valid    <= 1'b0;
      r_wid      <= '0;
      r_pc       <= '0;
      r_cause    <= '0;
    end else begin
      r_irq_prev <= i_irq_in;
      r_pending  <= w_pending_nxt;
      if (w_wr_hit && w_woff == OFF_CTRL)    r_gie     <= w_wdata[0];
      if (w_wr_hit && w_woff == OFF_ENABLE)  r_enable  <= w_wdata[NUM_SRCS-1:0];
      if (w_wr_hit && w_woff == OFF_TARGET)  r_target  <= w_wdata[WID_BITS-1:0];
      if (w_wr_hit && w_woff == OFF_HANDLER) r_handler <= w_wdata;
      case (r_state)
        ITR_IDLE: begin
          if (w_fire) begin
            r_cause <= w_idx;
            r_wid   <= r_target;
            r_pc    <= r_handler;
            r_valid <= 1'b1;
            r_state <= ITR_REQ;
          end
        end
        ITR_REQ: begin
          if (i_itr_ready) begin
            r_valid <= 1'b0;
            r_state <= ITR_ACTIVE;
          end
        end
        ITR_ACTIVE: begin
          if (w_wr_hit && w_woff == OFF_EOI) r_state <= ITR_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ITR_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (in_window(i_read_addr)) begin
      case (i_read_addr[2:0])
        OFF_CTRL:    w_rdata[0] = r_gie;
        OFF_ENABLE:  w_rdata[NUM_SRCS-1:0] = r_enable;
        OFF_PENDING: w_rdata[NUM_SRCS-1:0] = r_pending;
        OFF_CAUSE: begin
          w_rdata[31]           = (r_state == ITR_ACTIVE);
          w_rdata[SRC_BITS-1:0] = r_cause;
        end
        OFF_TARGET:  w_rdata[WID_BITS-1:0] = r_target;
        OFF_HANDLER: w_rdata = r_handler;
        default:     w_rdata = '0;
      endcase
    end
  end

  assign o_read_data = {NUM_LANES{w_rdata}};
  assign o_itr_valid = r_valid;
  assign o_itr_wid   = r_wid;
  assign o_itr_pc    = XLEN'(r_pc);
  assign o_itr_cause = r_cause;

endmodule

// File: tb/tb_vx_hw_itr_ctrl.sv
// tb/tb_vx_hw_itr_ctrl.sv - directed bench for vx_hw_itr_ctrl
module tb_vx_hw_itr_ctrl;
  import vx_hw_itr_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_enable;
  logic [11:0] read_addr;
  logic [31:0] read_data;
  logic        write_enable;
  logic [11:0] write_addr;
  logic [31:0] write_data;
  logic [7:0]  irq_in;
  logic        itr_valid;
  logic [1:0]  itr_wid;
  logic [31:0] itr_pc;
  logic [2:0]  itr_cause;
  logic        itr_ready;

  int n_checks = 0;
  int n_fail   = 0;

  vx_hw_itr_ctrl #(
    .NUM_LANES (1),
    .WARP_CNT  (4),
    .NUM_SRCS  (8),
    .XLEN      (32)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_read_enable  (read_enable),
    .i_read_addr    (read_addr),
    .o_read_data    (read_data),
    .i_write_enable (write_enable),
    .i_write_addr   (write_addr),
    .i_write_data   (write_data),
    .i_irq_in       (irq_in),
    .o_itr_valid    (itr_valid),
    .o_itr_wid      (itr_wid),
    .o_itr_pc       (itr_pc),
    .o_itr_cause    (itr_cause),
    .i_itr_ready    (itr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    write_enable = 1'b1;
    write_addr   = HW_ITR_CTRL_BEGIN + 12'(off);
    write_data   = data;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] data);
    read_enable = 1'b1;
    read_addr   = HW_ITR_CTRL_BEGIN + 12'(off);
    #1;
    data        = read_data;
    read_enable = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] v;
    rd(off, v);
    chk(name, v, exp);
  endtask

  task automatic accept();
    itr_ready = 1'b1;
    tick();
    itr_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] v;

    reset = 1'b1; read_enable = 1'b0; read_addr = '0; write_enable = 1'b0;
    write_addr = '0; write_data = '0; irq_in = '0; itr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk("reset_valid", 32'(itr_valid), 32'd0);
    chk("reset_wid",   32'(itr_wid),   32'd0);
    chk("reset_pc",    itr_pc,         32'd0);
    chk("reset_cause", 32'(itr_cause), 32'd0);
    chk_rd("reset_pending", OFF_PENDING, 32'd0);
    chk_rd("reset_handler", OFF_HANDLER, 32'd0);

    // Register write/readback table; unmapped addresses read 0 and ignore writes.
    vecs[0] = '{HW_ITR_CTRL_BEGIN + 12'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[1] = '{HW_ITR_CTRL_BEGIN + 12'd1, 1'b1, 32'h0000_01FF, 32'h0000_00FF};
    vecs[2] = '{HW_ITR_CTRL_BEGIN + 12'd4, 1'b1, 32'h0000_00FF, 32'h0000_0003};
    vecs[3] = '{HW_ITR_CTRL_BEGIN + 12'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4] = '{HW_ITR_CTRL_BEGIN + 12'd6, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{HW_ITR_CTRL_BEGIN + 12'd3, 1'b0, 32'h0,         32'h0000_0000};
    vecs[6] = '{HW_ITR_CTRL_END,           1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{HW_ITR_CTRL_BEGIN - 12'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{HW_ITR_CTRL_BEGIN + 12'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{HW_ITR_CTRL_BEGIN + 12'd1, 1'b1, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) begin
        write_enable = 1'b1;
        write_addr   = vecs[i].addr;
        write_data   = vecs[i].wdata;
        tick();
        write_enable = 1'b0;
      end
      read_addr = vecs[i].addr;
      #1;
      chk($sformatf("table_%0d", i), read_data, vecs[i].exp);
    end
    chk("table_no_valid", 32'(itr_valid), 32'd0);

    // Basic delivery: edge at cycle N, valid at N+2.
    wr(OFF_CTRL, 32'd1);
    wr(OFF_ENABLE, 32'h04);
    wr(OFF_TARGET, 32'd3);
    wr(OFF_HANDLER, 32'h8000_0100);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    chk("basic_valid_n1", 32'(itr_valid), 32'd0);
    tick();
    chk("basic_valid_n2", 32'(itr_valid), 32'd1);
    chk("basic_wid",      32'(itr_wid),   32'd3);
    chk("basic_pc",       itr_pc,         32'h8000_0100);
    chk("basic_cause",    32'(itr_cause), 32'd2);
    chk_rd("basic_pending", OFF_PENDING, 32'h00);
    accept();
    chk("basic_valid_acc", 32'(itr_valid), 32'd0);
    chk_rd("basic_cause_rd", OFF_CAUSE, 32'h8000_0002);
    wr(OFF_EOI, 32'd0);
    chk_rd("basic_cause_idle", OFF_CAUSE, 32'h0000_0002);

    // Priority and stalled handshake.
    wr(OFF_ENABLE, 32'hFF);
    wr(OFF_RAISE, 32'h28);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("prio_valid_%0d", i), 32'(itr_valid), 32'd1);
      chk($sformatf("prio_cause_%0d", i), 32'(itr_cause), 32'd3);
      tick();
    end
    wr(OFF_TARGET, 32'd1);
    chk("prio_wid_held", 32'(itr_wid), 32'd3);
    accept();
    chk_rd("prio_cause_rd", OFF_CAUSE, 32'h8000_0003);
    chk_rd("prio_pending",  OFF_PENDING, 32'h20);
    wr(OFF_EOI, 32'd0);
    tick();
    chk("prio_valid2", 32'(itr_valid), 32'd1);
    chk("prio_cause2", 32'(itr_cause), 32'd5);
    chk("prio_wid2",   32'(itr_wid),   32'd1);
    accept();
    wr(OFF_EOI, 32'd0);

    // Masking by GIE: pending accumulates, delivery starts two cycles after GIE set.
    wr(OFF_CTRL, 32'd0);
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    tick();
    chk("mask_valid", 32'(itr_valid), 32'd0);
    chk_rd("mask_pending", OFF_PENDING, 32'h02);
    wr(OFF_CTRL, 32'd1);
    chk("mask_valid_w1", 32'(itr_valid), 32'd0);
    tick();
    chk("mask_valid_w2", 32'(itr_valid), 32'd1);
    chk("mask_cause",    32'(itr_cause), 32'd1);
    accept();
    wr(OFF_EOI, 32'd0);

    // W1C against a simultaneous edge, then repeated W1C.
    wr(OFF_CTRL, 32'd0);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    chk_rd("w1c_pre", OFF_PENDING, 32'h01);
    irq_in = 8'h01;
    wr(OFF_PENDING, 32'h01);
    irq_in = 8'h00;
    chk_rd("w1c_collide", OFF_PENDING, 32'h01);
    write_enable = 1'b1;
    write_addr   = HW_ITR_CTRL_BEGIN + 12'(OFF_PENDING);
    write_data   = 32'h01;
    tick(); tick(); tick();
    write_enable = 1'b0;
    chk_rd("w1c_held", OFF_PENDING, 32'h00);

    // Repeated EOI gives exactly one return to IDLE and one delivery.
    wr(OFF_CTRL, 32'd1);
    wr(OFF_RAISE, 32'h01);
    tick();
    chk("eoi_first_cause", 32'(itr_cause), 32'd0);
    accept();
    wr(OFF_RAISE, 32'h10);
    tick();
    chk("eoi_active_hold", 32'(itr_valid), 32'd0);
    write_enable = 1'b1;
    write_addr   = HW_ITR_CTRL_BEGIN + 12'(OFF_EOI);
    write_data   = 32'd0;
    tick(); tick(); tick();
    write_enable = 1'b0;
    chk("eoi_valid", 32'(itr_valid), 32'd1);
    chk("eoi_cause", 32'(itr_cause), 32'd4);
    accept();
    chk_rd("eoi_cause_rd", OFF_CAUSE, 32'h8000_0004);
    v = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      v = v | 32'(itr_valid);
    end
    chk("eoi_no_double", v, 32'd0);
    chk_rd("eoi_pending", OFF_PENDING, 32'h00);

    // Reset while ACTIVE with irq_in[7] held high throughout.
    chk_rd("rst_pre_active", OFF_CAUSE, 32'h8000_0004);
    irq_in = 8'h80;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    chk("rst_valid", 32'(itr_valid), 32'd0);
    chk_rd("rst_ctrl",    OFF_CTRL,    32'd0);
    chk_rd("rst_enable",  OFF_ENABLE,  32'd0);
    chk_rd("rst_pending", OFF_PENDING, 32'd0);
    chk_rd("rst_cause",   OFF_CAUSE,   32'd0);
    chk_rd("rst_target",  OFF_TARGET,  32'd0);
    chk_rd("rst_handler", OFF_HANDLER, 32'd0);
    tick();
    chk_rd("rst_edge_pending", OFF_PENDING, 32'h80);
    irq_in = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
